interrupt_controller: RTL and testbench

Consumes the watchdog's preemption request and an external I/O interrupt line and decides when the CPU may actually take an interrupt. Defers interrupts until a safe instruction boundary: user mode only, never on a jump. Captures the return address and cause, then performs a request/acknowledge handshake with the control unit. Sits between the watchdog and the control unit / PC-select logic.

---
 rtl/izero_intc_pkg.sv | 31 +++
 rtl/irq_edge_detect.sv | 23 ++
 rtl/interrupt_controller.sv | 157 +++++++++++++++
 tb/tb_interrupt_controller.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/izero_intc_pkg.sv
// Shared interrupt-controller definitions: jump opcodes, cause codes and FSM encoding.
// The jump opcode constants are also consumed by the watchdog.
package izero_intc_pkg;

   localparam logic [5:0] OP_JR  = 6'b010010;
   localparam logic [5:0] OP_JF  = 6'b010101;
   localparam logic [5:0] OP_J   = 6'b111100;
   localparam logic [5:0] OP_JTM = 6'b111101;
   localparam logic [5:0] OP_JAL = 6'b111110;

   typedef enum logic [1:0] {
      CAUSE_NONE = 2'b00,
      CAUSE_WD   = 2'b01,
      CAUSE_IO   = 2'b10
   } cause_t;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'b00,
      ST_WAIT_SAFE = 2'b01,
      ST_REQ       = 2'b10,
      ST_HANDLER   = 2'b11
   } state_t;

   function automatic logic is_jump(input logic [5:0] op);
      case (op)
         OP_JR, OP_JF, OP_J, OP_JTM, OP_JAL: is_jump = 1'b1;
         default:                            is_jump = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/irq_edge_detect.sv
// Registered rising-edge detector: flags a cycle where sig is high but was low
// at the previous clock edge.
module irq_edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic sig,
   output logic rise
);

   logic sig_q_r;

   // one-cycle delayed copy of the input
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sig_q_r <= 1'b0;
      end else begin
         sig_q_r <= sig;
      end
   end

   assign rise = sig & ~sig_q_r;

endmodule

// File: rtl/interrupt_controller.sv
// Defers watchdog / I/O interrupts to a safe user-mode, non-jump boundary, latches
// epc and cause, then handshakes with the control unit. I/O source under INTC_IO_IRQ_EN.
module interrupt_controller
   import izero_intc_pkg::*;
#(
   parameter int PC_WIDTH = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                wd_irq,
   input  logic                io_irq,
   input  logic                isUser,
   input  logic [5:0]          opcode,
   input  logic                instr_valid,
   input  logic [PC_WIDTH-1:0] pc,
   input  logic                int_ack,
   input  logic                rfi,
   output logic                int_req,
   output logic [1:0]          cause,
   output logic [PC_WIDTH-1:0] epc,
   output logic                busy
);

   state_t              state_r;
   state_t              state_nxt_s;
   cause_t              cause_r;
   logic [PC_WIDTH-1:0] epc_r;
   logic                pend_wd_r;
   logic                pend_io_s;
   logic                int_req_r;
   logic                busy_r;
   logic                int_req_nxt_s;
   logic                busy_nxt_s;
   logic                safe_s;
   logic                capture_s;
   logic                ack_s;

   assign safe_s    = instr_valid & isUser & ~is_jump(opcode);
   assign capture_s = (state_r == ST_WAIT_SAFE) & safe_s;
   assign ack_s     = (state_r == ST_REQ) & int_ack;

`ifdef INTC_IO_IRQ_EN
   logic io_rise_s;
   logic pend_io_r;

   irq_edge_detect u_io_edge (
      .clk   (clk),
      .reset (reset),
      .sig   (io_irq),
      .rise  (io_rise_s)
   );

   // a new edge wins over an ack clearing the same bit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_io_r <= 1'b0;
      end else begin
         pend_io_r <= io_rise_s | (pend_io_r & ~(ack_s & (cause_r == CAUSE_IO)));
      end
   end

   assign pend_io_s = pend_io_r;
`else
   logic unused_io_s;
   assign unused_io_s = io_irq;
   assign pend_io_s   = 1'b0;
`endif

   // watchdog pending bit, only sampled before a request is raised
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_wd_r <= 1'b0;
      end else if (ack_s && (cause_r == CAUSE_WD)) begin
         pend_wd_r <= 1'b0;
      end else if (wd_irq && ((state_r == ST_IDLE) || (state_r == ST_WAIT_SAFE))) begin
         pend_wd_r <= 1'b1;
      end else begin
         pend_wd_r <= pend_wd_r;
      end
   end

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // next-state logic; rfi is only meaningful in HANDLER
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (isUser && (pend_io_s || pend_wd_r)) state_nxt_s = ST_WAIT_SAFE;
            else                                    state_nxt_s = ST_IDLE;
         end
         ST_WAIT_SAFE: begin
            if (!isUser)     state_nxt_s = ST_IDLE;
            else if (safe_s) state_nxt_s = ST_REQ;
            else             state_nxt_s = ST_WAIT_SAFE;
         end
         ST_REQ: begin
            if (int_ack) state_nxt_s = ST_HANDLER;
            else         state_nxt_s = ST_REQ;
         end
         ST_HANDLER: begin
            if (rfi) state_nxt_s = ST_IDLE;
            else     state_nxt_s = ST_HANDLER;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // outputs decoded from the next state so they can be registered without lag
   always_comb begin
      int_req_nxt_s = 1'b0;
      busy_nxt_s    = 1'b0;
      case (state_nxt_s)
         ST_REQ:     begin int_req_nxt_s = 1'b1; busy_nxt_s = 1'b1; end
         ST_HANDLER: begin int_req_nxt_s = 1'b0; busy_nxt_s = 1'b1; end
         default:    begin int_req_nxt_s = 1'b0; busy_nxt_s = 1'b0; end
      endcase
   end

   // registered handshake outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         int_req_r <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         int_req_r <= int_req_nxt_s;
         busy_r    <= busy_nxt_s;
      end
   end

   // capture of return address and cause; I/O has priority
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cause_r <= CAUSE_NONE;
         epc_r   <= {PC_WIDTH{1'b0}};
      end else if (capture_s) begin
         cause_r <= pend_io_s ? CAUSE_IO : CAUSE_WD;
         epc_r   <= pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};
      end else begin
         cause_r <= cause_r;
         epc_r   <= epc_r;
      end
   end

   assign int_req = int_req_r;
   assign busy    = busy_r;
   assign cause   = cause_r;
   assign epc     = epc_r;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural reference model.
module tb_interrupt_controller;

   localparam int PW = 32;
`ifdef INTC_IO_IRQ_EN
   localparam bit IO_EN = 1'b1;
`else
   localparam bit IO_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          wd_irq, io_irq, isUser, instr_valid, int_ack, rfi;
   logic [5:0]    opcode;
   logic [PW-1:0] pc;
   logic          int_req, busy;
   logic [1:0]    cause;
   logic [PW-1:0] epc;

   int total = 0;
   int bad   = 0;

   // reference model state
   bit            m_pio, m_pwd, m_ioprev;
   int            m_stage;   // 0 idle, 1 waiting for boundary, 2 requesting, 3 in handler
   logic [1:0]    m_cause;
   logic [PW-1:0] m_epc;

   logic [5:0] jump_ops [5] = '{6'b010010, 6'b010101, 6'b111100, 6'b111101, 6'b111110};

   interrupt_controller #(.PC_WIDTH(PW)) dut (
      .clk(clk), .reset(reset), .wd_irq(wd_irq), .io_irq(io_irq), .isUser(isUser),
      .opcode(opcode), .instr_valid(instr_valid), .pc(pc), .int_ack(int_ack), .rfi(rfi),
      .int_req(int_req), .cause(cause), .epc(epc), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   function automatic bit ref_is_jump(input logic [5:0] op);
      bit j;
      j = 1'b0;
      foreach (jump_ops[i]) if (jump_ops[i] == op) j = 1'b1;
      return j;
   endfunction

   task automatic model_step();
      bit rise, safe, ack, opio, opwd;
      rise     = IO_EN && io_irq && !m_ioprev;
      m_ioprev = io_irq;
      safe     = instr_valid && isUser && !ref_is_jump(opcode);
      ack      = (m_stage == 2) && int_ack;
      opio     = m_pio;
      opwd     = m_pwd;
      if (ack && m_cause == 2'b10) m_pio = 1'b0;
      if (ack && m_cause == 2'b01) m_pwd = 1'b0;
      if (rise) m_pio = 1'b1;
      if (wd_irq && m_stage < 2) m_pwd = 1'b1;
      case (m_stage)
         0: if (isUser && (opio || opwd)) m_stage = 1;
         1: begin
            if (!isUser) m_stage = 0;
            else if (safe) begin
               m_cause = opio ? 2'b10 : 2'b01;
               m_epc   = pc + 32'd1;
               m_stage = 2;
            end
         end
         2: if (int_ack) m_stage = 3;
         default: if (rfi) m_stage = 0;
      endcase
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      wd_irq = 1'b0; io_irq = 1'b0; isUser = 1'b1; instr_valid = 1'b1;
      opcode = 6'b000000; pc = 32'h0; int_ack = 1'b0; rfi = 1'b0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      m_pio = 1'b0; m_pwd = 1'b0; m_ioprev = 1'b0; m_stage = 0;
      m_cause = 2'b00; m_epc = 32'h0;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (int_req !== 1'b0) begin bad++; $display("FAIL reset_int_req: got %b want 0", int_req); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if (cause !== 2'b00) begin bad++; $display("FAIL reset_cause: got %b want 00", cause); end
      total++; if (epc !== 32'h0) begin bad++; $display("FAIL reset_epc: got %h want 0", epc); end
   endtask

   task automatic test_wd_latency();
      int n;
      do_reset();
      pc = 32'h0000_1000;
      n = 0;
      wd_irq = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (int_req === 1'b1) begin n = i; break; end
      end
      wd_irq = 1'b0;
      total++; if (n != 3) begin bad++; $display("FAIL wd_latency: got %0d cycles want 3", n); end
      total++; if (cause !== 2'b01) begin bad++; $display("FAIL wd_cause: got %b want 01", cause); end
      total++; if (epc !== 32'h0000_1001) begin bad++; $display("FAIL wd_epc: got %h want 00001001", epc); end
      // ack and rfi together: ack wins, handler stays active
      int_ack = 1'b1; rfi = 1'b1;
      tick();
      int_ack = 1'b0; rfi = 1'b0;
      total++; if (int_req !== 1'b0) begin bad++; $display("FAIL ack_int_req: got %b want 0", int_req); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL ack_busy: got %b want 1", busy); end
      tick();
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL handler_busy: got %b want 1", busy); end
      rfi = 1'b1;
      tick();
      rfi = 1'b0;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rfi_busy: got %b want 0", busy); end
   endtask

   task automatic test_jump_defer();
      do_reset();
      opcode = 6'b111100; pc = 32'h0000_3000;
      wd_irq = 1'b1;
      tick();
      wd_irq = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         pc = 32'h0000_3000 + i;
         tick();
         total++; if (int_req !== 1'b0) begin bad++; $display("FAIL jump_J_%0d: got int_req %b want 0", i, int_req); end
      end
      foreach (jump_ops[k]) begin
         opcode = jump_ops[k];
         tick();
         total++; if (int_req !== 1'b0) begin bad++; $display("FAIL jump_op_%0d: got int_req %b want 0", k, int_req); end
      end
      opcode = 6'b000000; pc = 32'h0000_2000;
      tick();
      total++; if (int_req !== 1'b1) begin bad++; $display("FAIL add_capture: got int_req %b want 1", int_req); end
      total++; if (epc !== 32'h0000_2001) begin bad++; $display("FAIL add_epc: got %h want 00002001", epc); end
   endtask

   task automatic test_both_sources();
      bit got;
      do_reset();
      wd_irq = 1'b1; io_irq = 1'b1;
      tick();
      wd_irq = 1'b0; io_irq = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin tick(); got = (int_req === 1'b1); end
      total++; if (!got) begin bad++; $display("FAIL both_first_req: got no request want request"); end
      total++; if (cause !== (IO_EN ? 2'b10 : 2'b01)) begin bad++; $display("FAIL both_first_cause: got %b want %b", cause, IO_EN ? 2'b10 : 2'b01); end
      int_ack = 1'b1; tick(); int_ack = 1'b0;
      rfi = 1'b1; tick(); rfi = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin tick(); got = (int_req === 1'b1); end
      total++; if (got !== IO_EN) begin bad++; $display("FAIL both_second_req: got %b want %b", got, IO_EN); end
      if (IO_EN) begin
         total++; if (cause !== 2'b01) begin bad++; $display("FAIL both_second_cause: got %b want 01", cause); end
      end
   endtask

   task automatic test_user_drop();
      do_reset();
      instr_valid = 1'b0;
      wd_irq = 1'b1;
      tick();
      wd_irq = 1'b0;
      tick();
      isUser = 1'b0; instr_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         total++; if (int_req !== 1'b0) begin bad++; $display("FAIL user_drop_%0d: got int_req %b want 0", i, int_req); end
      end
      isUser = 1'b1;
      tick();
      total++; if (int_req !== 1'b0) begin bad++; $display("FAIL user_back_wait: got int_req %b want 0", int_req); end
      tick();
      total++; if (int_req !== 1'b1) begin bad++; $display("FAIL user_back_req: got int_req %b want 1", int_req); end
      total++; if (cause !== 2'b01) begin bad++; $display("FAIL user_back_cause: got %b want 01", cause); end
   endtask

   task automatic test_pc_wrap();
      bit got;
      do_reset();
      pc = 32'hFFFF_FFFF;
      wd_irq = 1'b1;
      tick();
      wd_irq = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin tick(); got = (int_req === 1'b1); end
      total++; if (!got) begin bad++; $display("FAIL wrap_req: got no request want request"); end
      total++; if (epc !== 32'h0) begin bad++; $display("FAIL wrap_epc: got %h want 00000000", epc); end
   endtask

   task automatic test_reset_mid();
      bit got;
      do_reset();
      pc = 32'h0000_0040;
      wd_irq = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin tick(); got = (int_req === 1'b1); end
      total++; if (!got) begin bad++; $display("FAIL mid_req: got no request want request"); end
      #1;
      reset = 1'b1;
      #1;
      total++; if (int_req !== 1'b0) begin bad++; $display("FAIL mid_int_req: got %b want 0", int_req); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
      total++; if (cause !== 2'b00) begin bad++; $display("FAIL mid_cause: got %b want 00", cause); end
      total++; if (epc !== 32'h0) begin bad++; $display("FAIL mid_epc: got %h want 0", epc); end
      do_reset();
      for (int i = 0; i < 10; i++) begin
         tick();
         total++; if (int_req !== 1'b0) begin bad++; $display("FAIL post_reset_%0d: got int_req %b want 0", i, int_req); end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 2000; c++) begin
         wd_irq      = ($urandom_range(0, 9) == 0);
         io_irq      = ($urandom_range(0, 3) == 0) ? ~io_irq : io_irq;
         isUser      = ($urandom_range(0, 9) != 0);
         instr_valid = ($urandom_range(0, 4) != 0);
         opcode      = ($urandom_range(0, 2) == 0) ? jump_ops[$urandom_range(0, 4)] : 6'($urandom);
         pc          = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
         int_ack     = ($urandom_range(0, 3) == 0);
         rfi         = ($urandom_range(0, 3) == 0);
         tick();
         total++; if (int_req !== (m_stage == 2)) begin bad++; $display("FAIL rnd_int_req @%0d: got %b want %b", c, int_req, m_stage == 2); end
         total++; if (busy !== (m_stage >= 2)) begin bad++; $display("FAIL rnd_busy @%0d: got %b want %b", c, busy, m_stage >= 2); end
         total++; if (cause !== m_cause) begin bad++; $display("FAIL rnd_cause @%0d: got %b want %b", c, cause, m_cause); end
         total++; if (epc !== m_epc) begin bad++; $display("FAIL rnd_epc @%0d: got %h want %h", c, epc, m_epc); end
      end
   endtask

   initial begin
      test_reset();
      test_wd_latency();
      test_jump_defer();
      test_both_sources();
      test_user_drop();
      test_pc_wrap();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
